// File: rtl/stream_inverse_sched.sv
// Two-requester frame scheduler in front of a streaming inverse engine.
// Grants one frame at a time, loads it into the engine, then drains the results back to the owner.
module stream_inverse_sched #(
   parameter int WIDTH   = 32,
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic [LEN_W-1:0] len0,
   input  logic [LEN_W-1:0] len1,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   input  logic             vld0,
   input  logic             vld1,
   output logic             rdy0,
   output logic             rdy1,
   output logic [1:0]       gnt,
   output logic [WIDTH-1:0] eng_in,
   output logic             eng_in_valid,
   input  logic             eng_in_ready,
   input  logic [WIDTH-1:0] eng_out,
   input  logic             eng_out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             out_id,
   output logic             busy,
   output logic             err
);

   // state | meaning
   // IDLE  | no owner; arbitrate qualifying requests
   // LOAD  | owner's words stream into the engine
   // DRAIN | engine results stream back to the owner

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   state_t           state, state_nxt;
   logic             armed, owner, rr, err_q;
   logic [LEN_W-1:0] eff_len, ld_cnt, dr_cnt;
   logic             q0, q1, pick, grant;
   logic [LEN_W-1:0] len_pick, len_clamp;
   logic             ld_xfer, ld_last, dr_beat, dr_last;

   assign q0        = req0 && (len0 != '0);
   assign q1        = req1 && (len1 != '0);
   assign pick      = (q0 && q1) ? rr : q1;
   // armed holds off the first edge after reset release so grants start no earlier than the second
   assign grant     = armed && (state == IDLE) && (q0 || q1);
   assign len_pick  = pick ? len1 : len0;
   assign len_clamp = (len_pick > LEN_MAX) ? LEN_MAX : len_pick;
   assign ld_xfer   = (state == LOAD) && (owner ? vld1 : vld0) && eng_in_ready;
   assign ld_last   = ld_xfer && ((ld_cnt + LEN_ONE) == eff_len);
   assign dr_beat   = (state == DRAIN) && eng_out_valid;
   assign dr_last   = dr_beat && ((dr_cnt + LEN_ONE) == eff_len);
   assign err       = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      gnt          = 2'b00;
      rdy0         = 1'b0;
      rdy1         = 1'b0;
      eng_in       = '0;
      eng_in_valid = 1'b0;
      out_data     = '0;
      out_valid    = 1'b0;
      out_id       = 1'b0;
      busy         = 1'b0;
      case (state)
         IDLE: begin
            if (grant) state_nxt = LOAD;
         end
         LOAD: begin
            busy         = 1'b1;
            gnt          = owner ? 2'b10 : 2'b01;
            eng_in       = owner ? data1 : data0;
            eng_in_valid = owner ? vld1 : vld0;
            rdy0         = !owner && eng_in_ready;
            rdy1         = owner && eng_in_ready;
            if (ld_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy      = 1'b1;
            gnt       = owner ? 2'b10 : 2'b01;
            out_data  = eng_out;
            out_valid = eng_out_valid;
            out_id    = owner;
            if (dr_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         armed   <= 1'b0;
         owner   <= 1'b0;
         rr      <= 1'b0;
         eff_len <= '0;
         ld_cnt  <= '0;
         dr_cnt  <= '0;
         err_q   <= 1'b0;
      end else begin
         armed <= 1'b1;
         if (grant) begin
            owner   <= pick;
            eff_len <= len_clamp;
            ld_cnt  <= '0;
            dr_cnt  <= '0;
         end
         if (ld_xfer) ld_cnt <= ld_cnt + LEN_ONE;
         if (dr_beat) dr_cnt <= dr_cnt + LEN_ONE;
         if (dr_last) rr <= !owner;
         // engine output outside DRAIN has no owner to go to
         if (eng_out_valid && (state != DRAIN)) err_q <= 1'b1;
      end
   end

endmodule
